// File: rtl/cim_tile_sequencer_if.sv
// cim_tile_sequencer_if: bundle of every non-clock signal of the CIM tile sequencer.
//   Job control: start, w_base/x_base/y_base (to the sequencer), busy, done (from it).
//   Data RAM:    mem_addr, mem_rd, mem_wr, mem_wdata (from it), mem_rdata (to it).
//   CIM macro:   write, cim, partial_sum, reset_output, output_reg, address,
//                input_data (from it), cim_output (to it).
// The master modport is the sequencer; the slave modport is the RAM/CIM/host side.
interface cim_tile_sequencer_if;
  logic        start;
  logic [31:0] w_base;
  logic [31:0] x_base;
  logic [31:0] y_base;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        write;
  logic        cim;
  logic        partial_sum;
  logic        reset_output;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic [31:0] cim_output;

  modport master (
    input  start, w_base, x_base, y_base, mem_rdata, cim_output,
    output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata,
    output write, cim, partial_sum, reset_output, output_reg, address, input_data
  );

  modport slave (
    output start, w_base, x_base, y_base, mem_rdata, cim_output,
    input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  write, cim, partial_sum, reset_output, output_reg, address, input_data
  );
endinterface

// File: rtl/cim_tile_sequencer.sv
// cim_tile_sequencer: runs one matmul tile on the CIM macro without CPU help.
// Loads W_WORDS weights from RAM into CIM rows, then for each of ROWS input rows clears the
// output registers, issues K_STEPS compute commands (accumulating after the first) and drains
// OUT_COLS output registers back to RAM at y_base.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - master side of cim_tile_sequencer_if (job control, RAM port, CIM command port)
// Strobes and address-like operands are flops decoded from the next state. input_data and
// mem_wdata forward the RAM/CIM read data combinationally in the one state that consumes it
// (that data only arrives in that cycle) and otherwise hold the last forwarded value.
module cim_tile_sequencer #(
  parameter int unsigned W_WORDS  = 16,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned K_STEPS  = 4,
  parameter int unsigned OUT_COLS = 16  // must be <= 16: output_reg is 4 bits
) (
  input logic                   clk,
  input logic                   rst_n,
  cim_tile_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    StIdle, StWRd, StWWr, StRowClr, StXRd, StXCim, StOSel, StOWr, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q, w_d, r_q, r_d, k_q, k_d, c_q, c_d;
  logic [31:0] w_base_q, w_base_d, x_base_q, x_base_d, y_base_q, y_base_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic        write_q, write_d, cim_q, cim_d, partial_sum_q, partial_sum_d;
  logic        reset_output_q, reset_output_d;
  logic [3:0]  output_reg_q, output_reg_d;
  logic [31:0] address_q, address_d, mem_addr_q, mem_addr_d;
  logic [31:0] input_data_q, mem_wdata_q;
  logic [31:0] input_data, mem_wdata;

  // Next state and loop counters.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    r_d      = r_q;
    k_d      = k_q;
    c_d      = c_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StWRd;
          w_base_d = bus.w_base;
          x_base_d = bus.x_base;
          y_base_d = bus.y_base;
          w_d      = '0;
          r_d      = '0;
          k_d      = '0;
          c_d      = '0;
        end
      end
      StWRd: state_d = StWWr;
      StWWr: begin
        if (w_q < W_WORDS - 1) begin
          w_d     = w_q + 32'd1;
          state_d = StWRd;
        end else begin
          state_d = StRowClr;
        end
      end
      StRowClr: begin
        k_d     = '0;
        state_d = StXRd;
      end
      StXRd: state_d = StXCim;
      StXCim: begin
        if (k_q < K_STEPS - 1) begin
          k_d     = k_q + 32'd1;
          state_d = StXRd;
        end else begin
          c_d     = '0;
          state_d = StOSel;
        end
      end
      StOSel: state_d = StOWr;
      StOWr: begin
        if (c_q < OUT_COLS - 1) begin
          c_d     = c_q + 32'd1;
          state_d = StOSel;
        end else if (r_q < ROWS - 1) begin
          r_d     = r_q + 32'd1;
          state_d = StRowClr;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs for the state being entered; operands hold outside their state.
  always_comb begin
    busy_d         = (state_d != StIdle);
    done_d         = (state_d == StDone);
    mem_rd_d       = (state_d == StWRd) || (state_d == StXRd);
    mem_wr_d       = (state_d == StOWr);
    write_d        = (state_d == StWWr);
    cim_d          = (state_d == StXCim);
    partial_sum_d  = (state_d == StXCim) && (k_d != '0);
    reset_output_d = (state_d == StRowClr);
    address_d      = address_q;
    mem_addr_d     = mem_addr_q;
    output_reg_d   = output_reg_q;
    case (state_d)
      StWRd:   mem_addr_d   = w_base_d + (w_d << 2);
      StWWr:   address_d    = w_d;
      StXRd:   mem_addr_d   = x_base_d + ((r_d * K_STEPS + k_d) << 2);
      StXCim:  address_d    = k_d;
      StOSel:  output_reg_d = c_d[3:0];
      StOWr:   mem_addr_d   = y_base_d + ((r_d * OUT_COLS + c_d) << 2);
      default: ;
    endcase
  end

  assign input_data = ((state_q == StWWr) || (state_q == StXCim)) ? bus.mem_rdata
                                                                   : input_data_q;
  assign mem_wdata  = (state_q == StOWr) ? bus.cim_output : mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      w_q            <= '0;
      r_q            <= '0;
      k_q            <= '0;
      c_q            <= '0;
      w_base_q       <= '0;
      x_base_q       <= '0;
      y_base_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      write_q        <= 1'b0;
      cim_q          <= 1'b0;
      partial_sum_q  <= 1'b0;
      reset_output_q <= 1'b0;
      output_reg_q   <= '0;
      address_q      <= '0;
      mem_addr_q     <= '0;
      input_data_q   <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      r_q            <= r_d;
      k_q            <= k_d;
      c_q            <= c_d;
      w_base_q       <= w_base_d;
      x_base_q       <= x_base_d;
      y_base_q       <= y_base_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      write_q        <= write_d;
      cim_q          <= cim_d;
      partial_sum_q  <= partial_sum_d;
      reset_output_q <= reset_output_d;
      output_reg_q   <= output_reg_d;
      address_q      <= address_d;
      mem_addr_q     <= mem_addr_d;
      input_data_q   <= input_data;
      mem_wdata_q    <= mem_wdata;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.write        = write_q;
  assign bus.cim          = cim_q;
  assign bus.partial_sum  = partial_sum_q;
  assign bus.reset_output = reset_output_q;
  assign bus.output_reg   = output_reg_q;
  assign bus.address      = address_q;
  assign bus.input_data   = input_data;

endmodule

// File: tb/tb_cim_tile_sequencer.sv
// tb_cim_tile_sequencer: self-checking bench for cim_tile_sequencer at default parameters.
// Provides a read-only RAM model and a behavioural CIM macro (out[j] accumulates
// x * weight[(4*block + j) mod 16]); expected RAM writes come from an independent reference
// of that product and are queued when each job starts, then popped as writes appear.
module tb_cim_tile_sequencer;
  localparam int unsigned W_WORDS  = 16;
  localparam int unsigned ROWS     = 8;
  localparam int unsigned K_STEPS  = 4;
  localparam int unsigned OUT_COLS = 16;
  localparam int          LAT      = 2 * W_WORDS + ROWS * (1 + 2 * K_STEPS + 2 * OUT_COLS) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cim_tile_sequencer_if bus ();

  cim_tile_sequencer #(
    .W_WORDS (W_WORDS),
    .ROWS    (ROWS),
    .K_STEPS (K_STEPS),
    .OUT_COLS(OUT_COLS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM: read data one cycle after mem_rd; writes are only checked, never stored.
  logic [31:0] ram [logic [31:0]];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'hDEADBEEF;
  end

  // Behavioural CIM macro.
  logic [31:0] wrow [16];
  logic [31:0] oreg [16];
  always @(posedge clk) begin
    if (bus.write) wrow[bus.address[3:0]] <= bus.input_data;
    if (bus.reset_output) for (int j = 0; j < 16; j++) oreg[j] <= '0;
    if (bus.cim)
      for (int j = 0; j < 16; j++)
        oreg[j] <= (bus.partial_sum ? oreg[j] : 32'd0)
                   + bus.input_data * wrow[4'({bus.address[1:0], 2'b00} + j)];
    bus.cim_output <= oreg[bus.output_reg];
  end

  function automatic logic [31:0] wpat(input int p, input int i);
    case (p)
      0:       return 32'd1;
      1:       return 32'(i * 3 + 1);
      default: return 32'h0001_0001 * 32'(i + 1);
    endcase
  endfunction

  function automatic logic [31:0] xpat(input int p, input int r, input int k);
    case (p)
      0:       return 32'd1;
      1:       return 32'(r * 7 + k + 2);
      default: return 32'hF000_0000 + 32'(r * 16 + k);
    endcase
  endfunction

  function automatic logic [31:0] yref(input int p, input int r, input int c);
    logic [31:0] s = '0;
    for (int k = 0; k < 4; k++) s += xpat(p, r, k) * wpat(p, (4 * k + c) % 16);
    return s;
  endfunction

  typedef struct {
    logic [31:0] wb, xb, yb;
    int          pat;
    int          exp_lat;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t sb_q[$];

  // Monitor state shared with the main sequence.
  int          wr_cnt, rst_cnt, done_cnt = 0, kcnt = 0, exp_w = 0;
  logic [31:0] last_wr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        int s;
        s = $countones({bus.write, bus.cim, bus.reset_output, bus.mem_rd, bus.mem_wr});
        if (s != 0) chk("strobe_excl", 32'(s), 32'd1);
        if (!bus.busy) exp_w = 0;
        if (bus.write) begin
          chk("w_wr_addr", bus.address, 32'(exp_w));
          exp_w++;
        end
        if (bus.reset_output) begin
          rst_cnt++;
          kcnt = 0;
        end
        if (bus.cim) begin
          chk("partial_sum", 32'(bus.partial_sum), 32'(kcnt != 0));
          kcnt++;
        end else if (bus.partial_sum) begin
          chk("partial_sum_idle", 32'(bus.partial_sum), 32'd0);
        end
        if (bus.done) done_cnt++;
        if (bus.mem_wr) begin
          wr_cnt++;
          last_wr = bus.mem_addr;
          if (sb_q.size() == 0) begin
            chk("unexpected_wr", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = sb_q.pop_front();
            chk("wr_addr", bus.mem_addr, e.a);
            chk("wr_data", bus.mem_wdata, e.d);
          end
        end
      end
    end
  end

  task automatic load_job(input vec_t v);
    ram.delete();
    for (int i = 0; i < 16; i++) ram[v.wb + 32'(4 * i)] = wpat(v.pat, i);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 4; k++) ram[v.xb + 32'(4 * (r * 4 + k))] = xpat(v.pat, r, k);
  endtask

  task automatic push_job(input vec_t v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        wr_t e;
        e.a = v.yb + 32'(4 * (r * 16 + c));
        e.d = yref(v.pat, r, c);
        sb_q.push_back(e);
      end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({bus.busy, bus.done, bus.mem_rd, bus.mem_wr, bus.write, bus.cim,
                             bus.partial_sum, bus.reset_output, bus.output_reg}), 32'd0);
    chk({tag, "_address"}, bus.address, 32'd0);
    chk({tag, "_input_data"}, bus.input_data, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  // Pulses start for one cycle; t0 is the accept cycle.
  task automatic kick(input vec_t v, output int t0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.w_base = v.wb;
    bus.x_base = v.xb;
    bus.y_base = v.yb;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int t0, lat, d0;
    load_job(v);
    push_job(v);
    wr_cnt  = 0;
    rst_cnt = 0;
    d0      = done_cnt;
    kick(v, t0);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    repeat (3) @(negedge clk);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("wr_count", 32'(wr_cnt), 32'd128);
    chk("last_wr", last_wr, v.exp_last);
    chk("rst_pulses", 32'(rst_cnt), 32'd8);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  vec_t vecs[4];

  initial begin
    int t0, d0, first, second;
    vecs[0] = '{wb: 32'h0,    xb: 32'h100,  yb: 32'h8000,      pat: 0, exp_lat: LAT,
                exp_last: 32'h81FC};
    vecs[1] = '{wb: 32'h1000, xb: 32'h2000, yb: 32'h3000,      pat: 1, exp_lat: LAT,
                exp_last: 32'h31FC};
    vecs[2] = '{wb: 32'h400,  xb: 32'h800,  yb: 32'hFFFF_FFF0, pat: 2, exp_lat: LAT,
                exp_last: 32'h1EC};
    vecs[3] = '{wb: 32'h5001, xb: 32'h6002, yb: 32'h7003,      pat: 1, exp_lat: LAT,
                exp_last: 32'h71FF};

    bus.start  = 1'b0;
    bus.w_base = '0;
    bus.x_base = '0;
    bus.y_base = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_job(vecs[i]);

    // Reset in the middle of the first X_CIM abandons the job without done.
    load_job(vecs[1]);
    push_job(vecs[1]);
    d0 = done_cnt;
    kick(vecs[1], t0);
    first = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.cim) begin
        first = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk("first_cim_cycle", 32'(first), 32'(2 * W_WORDS + 3));
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    repeat (5) @(negedge clk);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(vecs[0]);

    // start held for 400 cycles: one job, re-accept on the first IDLE cycle, two dones.
    load_job(vecs[1]);
    push_job(vecs[1]);
    push_job(vecs[1]);
    d0 = done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.w_base = vecs[1].wb;
    bus.x_base = vecs[1].xb;
    bus.y_base = vecs[1].yb;
    t0     = cyc;
    first  = -1;
    second = -1;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (bus.done && first == -1) first = cyc - t0;
      if (cyc == t0 + LAT + 1) chk("hold_busy_gap", 32'(bus.busy), 32'd0);
      if (cyc == t0 + LAT + 2) chk("hold_reaccept", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        second = cyc - t0;
        break;
      end
    end
    chk("hold_first_done", 32'(first), 32'(LAT));
    chk("hold_second_done", 32'(second), 32'(2 * LAT + 1));
    repeat (3) @(negedge clk);
    chk("hold_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("hold_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cim_tile_sequencer.md
# cim_tile_sequencer

Hardware initiator for the Basic_GeMM_CIM macro command interface. It takes over the one-tile matmul flow the darkriscv core currently performs in software. On a start pulse it streams weight words from data RAM into the CIM array. It then issues compute commands row by row, with partial-sum accumulation. Finally it reads back each output register and writes the results to RAM at the output base. It sits between the data RAM port and the CIM macro, in parallel with the CPU.

## Interface
Parameters:
- W_WORDS, 16: weight words loaded into CIM rows 0..W_WORDS-1.
- ROWS, 8: input rows per tile (output height).
- K_STEPS, 4: input words per row; each is one `cim` command; weight block index = step.
- OUT_COLS, 16: output registers drained per row (≤16, `output_reg` is 4 bits).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `w_base`, `x_base`, `y_base` in 32 each: byte addresses of weights, inputs and outputs; latched on accepted start.
- `busy` out 1: high from the cycle after accept until DONE exits.
- `done` out 1: one-cycle pulse in the DONE state.
- `mem_addr` out 32: word-aligned byte address.
- `mem_rd` out 1: read strobe.
- `mem_wr` out 1: write strobe.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd`.
- `write` out 1: CIM weight write; `address` selects the row, `input_data` is the weight.
- `cim` out 1: CIM compute; `input_data` is the activation word, `address` is the weight block.
- `partial_sum` out 1: with `cim`, accumulate into the output registers instead of overwriting them.
- `reset_output` out 1: clear all CIM output registers.
- `output_reg` out 4: output register select for `cim_output`.
- `address` out 32, `input_data` out 32: CIM command operands.
- `cim_output` in 32: selected output register, valid one cycle after `output_reg` changes.

## Operation
States and transitions:
- IDLE: `start` → W_RD. Latch the bases and clear counters w=r=k=c=0.
- W_RD: `mem_rd`=1, `mem_addr`=w_base+4w → W_WR.
- W_WR: `write`=1, `address`=w, `input_data`=`mem_rdata`. If w<W_WORDS-1, w++ → W_RD; else → ROW_CLR.
- ROW_CLR: `reset_output`=1, k=0 → X_RD.
- X_RD: `mem_rd`=1, `mem_addr`=x_base+4(r·K_STEPS+k) → X_CIM.
- X_CIM: `cim`=1, `address`=k, `input_data`=`mem_rdata`, `partial_sum`=(k≠0). If k<K_STEPS-1, k++ → X_RD; else c=0 → O_SEL.
- O_SEL: `output_reg`=c → O_WR.
- O_WR: `mem_wr`=1, `mem_addr`=y_base+4(r·OUT_COLS+c), `mem_wdata`=`cim_output`.
  - If c<OUT_COLS-1: c++ → O_SEL.
  - Else if r<ROWS-1: r++ → ROW_CLR.
  - Else → DONE.
- DONE: `done`=1 → IDLE.

Rules:
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. No alignment check; the low two bits of the bases pass through unchanged.
- At most one of `write`, `cim`, `reset_output`, `mem_rd`, `mem_wr` is high in any cycle.
- `output_reg` holds its value through the following O_WR.
- `start` while busy is ignored: no queueing, no restart.
- Command strobes and `mem_rd`/`mem_wr` are registered. All strobes are 0 outside their state. Operand buses hold their last value.

## Timing
- Reset: all outputs 0, including `output_reg`, `address`, `input_data`, `mem_addr` and `mem_wdata`. State returns to IDLE immediately (asynchronous). A reset mid-job abandons it with no `done`; RAM and CIM contents are not rolled back.
- Accept-to-`done` latency: 2·W_WORDS + ROWS·(1 + 2·K_STEPS + 2·OUT_COLS) + 1 cycles. Defaults: 32 + 8·41 + 1 = 361.
- `busy` falls in the cycle after `done`. `start` asserted in the same cycle as `done` is ignored; `start` in the following IDLE cycle is accepted.
- The first output write of each row occurs 2 cycles after the last `cim` of that row.

## Test plan
- Reset mid-X_CIM (rst_n low for 1 cycle) → all outputs 0 next sample, no `done`, `busy`=0. A new start then runs the full 361 cycles.
- Default parameters, all weights 1, all inputs 1, bases 0x0/0x100/0x8000 → `done` exactly 361 cycles after accept. 128 RAM writes at 0x8000..0x81FC, each value matching the CIM model.
- K_STEPS=1 → `partial_sum` never asserted; K_STEPS=4 → `partial_sum`=0,1,1,1 on the `cim` commands of each row; `reset_output` pulses exactly 8 times.
- `start` held high for 400 cycles → exactly one job during busy, a second accepted on the cycle after `busy` falls, two `done` pulses total.
- y_base=0xFFFFFFF0, OUT_COLS=16 → write addresses wrap 0xFFFFFFF0..0xFFFFFFFC, then 0x0..0x2C.
- Protocol checker across all runs → mutual-exclusion of strobes holds every cycle; `address` of W_WR runs 0..W_WORDS-1 in order.
